sodor_lockstep_lb_monitor: RTL and testbench
============================================

// Module: sodor_lockstep_lb_monitor
// PURPOSE
// - N-copy lockstep harness controller for Sodor 5-stage security BMC/sim benches.
// - Sequences core reset and warm-up, then compares every copy's load-buffer (LB) table against copy 0.
// - Reports sticky divergence with the first offending cycle, copy and entry.
// - Generalises the fixed 2-copy, 1-entry, single-cycle check to NUM_COPIES copies, LB_ENTRIES entries and a check window.
// PARAMETERS
// - NUM_COPIES    2   core instances compared (>=2); copy 0 is the golden copy
// - LB_ENTRIES    1   LB table entries per copy (>=1)
// - ADDR_W        32  LB entry address width
// - DATA_W        32  LB entry data width
// - RESET_CYCLES  2   cycles core_reset is held after monitor reset (>=1)
// - WARMUP_CYCLES 6   cycles after core_reset release before the check window opens
// - CHECK_START   14  cycle-counter value at which the check window opens
// - CHECK_LEN     1   check-window length in cycles (>=1)
// - CNT_W         8   cycle-counter width; saturates at all-ones
// PORTS
// - clk            in   1                          single clock
// - reset          in   1                          synchronous, active-high
// - lb_valid       in   NUM_COPIES*LB_ENTRIES      flattened; index = copy*LB_ENTRIES+entry
// - lb_addr        in   NUM_COPIES*LB_ENTRIES*ADDR_W  same flattening
// - lb_data        in   NUM_COPIES*LB_ENTRIES*DATA_W  same flattening
// - core_reset     out  1                          drives the reset port of every core copy
// - init           out  1                          high until warm-up completes
// - check_win      out  1                          high during the check window
// - diverge_now    out  1                          registered: divergence seen in previous window cycle
// - diverge_sticky out  1                          set on the first divergence; cleared only by reset
// - first_cycle    out  CNT_W                      counter value of the first divergence
// - first_copy     out  $clog2(NUM_COPIES)         copy index of the first divergence (lowest wins)
// - first_entry    out  $clog2(LB_ENTRIES)+1       entry index of the first divergence (lowest wins)
// - done           out  1                          window closed; remains high
// - pass           out  1                          done && !diverge_sticky
// BEHAVIOUR
// - Reset values: core_reset=1, init=1, check_win=0, diverge_now=0, diverge_sticky=0, first_*=0, done=0, pass=0; counter=0.
// - FSM states: S_RST -> S_WARM -> S_IDLE -> S_CHECK -> S_DONE.
//   S_RST: hold for RESET_CYCLES cycles.
//   S_WARM: core_reset=0 for WARMUP_CYCLES cycles, then init=0.
//   S_IDLE: wait until counter==CHECK_START.
//   S_CHECK: check_win=1 for CHECK_LEN cycles.
//   S_DONE: absorbing state.
// - Counter: increments every cycle after reset and saturates at 2^CNT_W-1.
// - If CHECK_START <= RESET_CYCLES+WARMUP_CYCLES, S_CHECK is entered directly after S_WARM.
// - Per-entry mismatch for copy k>0 vs copy 0:
//   (v_k ^ v_0) | (v_k & v_0 & (addr_k!=addr_0 | data_k!=data_0)).
//   Entries invalid in both copies never mismatch.
// - Mismatches are evaluated only while check_win=1; diverge_now is registered with 1-cycle latency.
// - First capture: on the first cycle any mismatch occurs with diverge_sticky=0, latch the counter, the lowest mismatching copy and the lowest entry within it.
// - Later mismatches never overwrite first_*.
// - done rises the cycle after the last window cycle; pass is valid only when done=1.
// - Reset asserted mid-run (any state): return to S_RST with all outputs at reset values on the next edge.
// CONFIGURATION
// - SODOR_LOCKSTEP_FORMAL_EN defined:
//   - Under FORMAL, emit assert(!diverge_now) every cycle in S_CHECK and the cycle after.
//   - Emit assume(reset) in the initial cycle.
// - SODOR_LOCKSTEP_FORMAL_EN undefined:
//   - No assert/assume; results are visible only through diverge_* and pass.
// - RTL behaviour is identical in both builds.
// STRUCTURE
// - Package sodor_lockstep_pkg:
//   - FSM state enum (S_RST..S_DONE)
//   - lb_entry_t struct {valid, addr, data}
//   - index-width helper function
// - Sub-module sodor_lb_entry_cmp: combinational compare of one entry pair, producing the mismatch bit.
//   Instantiated (NUM_COPIES-1)*LB_ENTRIES times via generate.
// - Top level holds the FSM, counter, capture registers and priority encoder.
// TESTING
// - Identical LB inputs on all copies, defaults -> core_reset falls at cycle 2, init falls at cycle 8, check_win=1 at cycle 14, done=1 at cycle 15, pass=1.
// - NUM_COPIES=2, copy1 valid=1 while copy0 valid=0 at cycle 14 -> diverge_now=1 at cycle 15, sticky=1, first_cycle=14, first_copy=1, pass=0.
// - NUM_COPIES=3, LB_ENTRIES=4, CHECK_LEN=4:
//   - cycle 15: copy2 entry3 data 0x10 vs 0x11
//   - cycle 16: copy1 entry0 mismatch
//   -> first_cycle=15, first_copy=2, first_entry=3, unchanged afterwards.
// - Both copies invalid with differing addr 0x100 vs 0x200 -> no divergence, pass=1.
// - Mismatch at cycle 10 (outside window) -> ignored, pass=1.
// - Reset pulsed at cycle 15 after a divergence -> all outputs at reset values; rerun with equal inputs -> pass=1.

Source files
------------

// File: rtl/sodor_lockstep_pkg.sv
// ---------------------------------------------------------------------------
// sodor_lockstep_pkg
// Shared types for the Sodor lockstep load-buffer monitor:
//   - state_e     : harness sequencing FSM states (S_RST .. S_DONE)
//   - lb_entry_t  : one load-buffer entry {valid, addr, data}. Fields are sized
//                   to the widest supported entry; narrower entries are
//                   zero-extended, which leaves equality unchanged.
//   - idx_w()     : index width for n items, never less than 1 bit
// ---------------------------------------------------------------------------
package sodor_lockstep_pkg;

  localparam int LB_MAX_ADDR_W = 64;
  localparam int LB_MAX_DATA_W = 64;

  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_WARM  = 3'd1,
    S_IDLE  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic                     valid;
    logic [LB_MAX_ADDR_W-1:0] addr;
    logic [LB_MAX_DATA_W-1:0] data;
  } lb_entry_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sodor_lb_entry_cmp.sv
// ---------------------------------------------------------------------------
// sodor_lb_entry_cmp
// Combinational comparison of one load-buffer entry of a checked copy against
// the same entry of the golden copy (copy 0).
//   golden   in  lb_entry_t  entry from copy 0
//   other    in  lb_entry_t  entry from copy k > 0
//   mismatch out 1           valid bits differ, or both valid and addr/data differ
// Entries invalid in both copies never mismatch, whatever their addr/data.
// ---------------------------------------------------------------------------
module sodor_lb_entry_cmp
  import sodor_lockstep_pkg::*;
(
  input  lb_entry_t golden,
  input  lb_entry_t other,
  output logic      mismatch
);

  logic both_valid;
  logic payload_diff;

  assign both_valid   = golden.valid & other.valid;
  assign payload_diff = (golden.addr != other.addr) | (golden.data != other.data);
  assign mismatch     = (golden.valid ^ other.valid) | (both_valid & payload_diff);

endmodule

// File: rtl/sodor_lockstep_lb_monitor.sv
// ---------------------------------------------------------------------------
// sodor_lockstep_lb_monitor
// N-copy lockstep harness controller. Sequences core reset and warm-up, opens
// a check window, and compares every copy's load-buffer table against copy 0.
// The first divergence (cycle, lowest copy, lowest entry in that copy) is
// latched and held until reset.
//
// Ports
//   clk            in   1                        single clock
//   reset          in   1                        synchronous, active-high
//   lb_valid       in   NUM_COPIES*LB_ENTRIES    index = copy*LB_ENTRIES+entry
//   lb_addr        in   ..*ADDR_W                same flattening
//   lb_data        in   ..*DATA_W                same flattening
//   core_reset     out  1                        reset for every core copy
//   init           out  1                        high until warm-up completes
//   check_win      out  1                        high during the check window
//   diverge_now    out  1                        mismatch in previous window cycle
//   diverge_sticky out  1                        first divergence seen
//   first_cycle    out  CNT_W                    counter value at first divergence
//   first_copy     out  clog2(NUM_COPIES)        copy of first divergence
//   first_entry    out  clog2(LB_ENTRIES)+1      entry of first divergence
//   done           out  1                        window closed (sticky)
//   pass           out  1                        done && !diverge_sticky
//
// Optional build macro: SODOR_LOCKSTEP_FORMAL_EN (with FORMAL) adds an
// assumption that reset is high in the initial cycle and an assertion that
// diverge_now stays low in S_CHECK and the cycle after. RTL behaviour is the
// same with or without it.
//
// Assumes WARMUP_CYCLES >= 1, ADDR_W/DATA_W <= 64 and that CHECK_START is
// reachable before the counter saturates.
// ---------------------------------------------------------------------------
module sodor_lockstep_lb_monitor
  import sodor_lockstep_pkg::*;
#(
  parameter int NUM_COPIES    = 2,
  parameter int LB_ENTRIES    = 1,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int RESET_CYCLES  = 2,
  parameter int WARMUP_CYCLES = 6,
  parameter int CHECK_START   = 14,
  parameter int CHECK_LEN     = 1,
  parameter int CNT_W         = 8,
  localparam int COPY_W       = idx_w(NUM_COPIES),
  localparam int ENTRY_W      = $clog2(LB_ENTRIES) + 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_COPIES*LB_ENTRIES-1:0]        lb_valid,
  input  logic [NUM_COPIES*LB_ENTRIES*ADDR_W-1:0] lb_addr,
  input  logic [NUM_COPIES*LB_ENTRIES*DATA_W-1:0] lb_data,
  output logic                                core_reset,
  output logic                                init,
  output logic                                check_win,
  output logic                                diverge_now,
  output logic                                diverge_sticky,
  output logic [CNT_W-1:0]                    first_cycle,
  output logic [COPY_W-1:0]                   first_copy,
  output logic [ENTRY_W-1:0]                  first_entry,
  output logic                                done,
  output logic                                pass
);

  localparam int NUM_ENT  = NUM_COPIES * LB_ENTRIES;
  localparam int NUM_CMP  = (NUM_COPIES - 1) * LB_ENTRIES;
  localparam int WARM_END = RESET_CYCLES + WARMUP_CYCLES;
  localparam int WIN_W    = idx_w(CHECK_LEN);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] RST_END_C  = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] WARM_END_C = CNT_W'(WARM_END);
  localparam logic [CNT_W-1:0] START_C    = CNT_W'(CHECK_START);
  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(CHECK_LEN - 1);
  // A start at or before the end of warm-up opens the window right after it.
  localparam bit START_IN_WARM = (CHECK_START <= WARM_END);

  // -------------------------------------------------------------------------
  // Unpack flattened LB ports into entries and compare against copy 0.
  // -------------------------------------------------------------------------
  lb_entry_t          ent [NUM_ENT];
  logic [NUM_CMP-1:0] mm;

  for (genvar i = 0; i < NUM_ENT; i++) begin : g_unpack
    assign ent[i] = '{valid: lb_valid[i],
                      addr:  LB_MAX_ADDR_W'(lb_addr[i*ADDR_W +: ADDR_W]),
                      data:  LB_MAX_DATA_W'(lb_data[i*DATA_W +: DATA_W])};
  end

  for (genvar k = 1; k < NUM_COPIES; k++) begin : g_copy
    for (genvar e = 0; e < LB_ENTRIES; e++) begin : g_entry
      sodor_lb_entry_cmp u_cmp (
        .golden   (ent[e]),
        .other    (ent[k*LB_ENTRIES + e]),
        .mismatch (mm[(k-1)*LB_ENTRIES + e])
      );
    end
  end

  // -------------------------------------------------------------------------
  // Priority encoder: scanning from the top down leaves the lowest copy, and
  // the lowest entry within that copy, as the final assignment.
  // -------------------------------------------------------------------------
  logic               hit;
  logic [COPY_W-1:0]  hit_copy;
  logic [ENTRY_W-1:0] hit_entry;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    hit       = 1'b0;
    hit_copy  = '0;
    hit_entry = '0;
    for (int k = NUM_COPIES - 1; k >= 1; k--) begin
      for (int e = LB_ENTRIES - 1; e >= 0; e--) begin
        if (mm[(k-1)*LB_ENTRIES + e]) begin
          hit       = 1'b1;
          hit_copy  = COPY_W'(k);
          hit_entry = ENTRY_W'(e);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sequencing FSM, saturating cycle counter and divergence capture.
  // Transitions look at the counter value of the next cycle so the registered
  // outputs change exactly on the cycle whose counter value matches.
  // -------------------------------------------------------------------------
  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [WIN_W-1:0]  win_cnt;

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_RST;
      cnt            <= '0;
      win_cnt        <= '0;
      core_reset     <= 1'b1;
      init           <= 1'b1;
      check_win      <= 1'b0;
      diverge_now    <= 1'b0;
      diverge_sticky <= 1'b0;
      first_cycle    <= '0;
      first_copy     <= '0;
      first_entry    <= '0;
      done           <= 1'b0;
    end else begin
      cnt         <= cnt_inc;
      diverge_now <= check_win & hit;

      // Only the first divergence is recorded; later ones leave first_* alone.
      if (check_win && hit && !diverge_sticky) begin
        diverge_sticky <= 1'b1;
        first_cycle    <= cnt;
        first_copy     <= hit_copy;
        first_entry    <= hit_entry;
      end

      unique case (state)
        S_RST: begin
          if (cnt_inc == RST_END_C) begin
            state      <= S_WARM;
            core_reset <= 1'b0;
          end
        end
        S_WARM: begin
          if (cnt_inc == WARM_END_C) begin
            init <= 1'b0;
            if (START_IN_WARM) begin
              state     <= S_CHECK;
              check_win <= 1'b1;
              win_cnt   <= '0;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_IDLE: begin
          if (cnt_inc == START_C) begin
            state     <= S_CHECK;
            check_win <= 1'b1;
            win_cnt   <= '0;
          end
        end
        S_CHECK: begin
          if (win_cnt == WIN_LAST) begin
            state     <= S_DONE;
            check_win <= 1'b0;
            done      <= 1'b1;
          end else begin
            win_cnt <= win_cnt + WIN_W'(1);
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_RST;
        end
      endcase
    end
  end

  assign pass = done & ~diverge_sticky;

`ifdef SODOR_LOCKSTEP_FORMAL_EN
`ifdef FORMAL
  logic f_past_valid = 1'b0;
  logic f_after_check = 1'b0;

  always_ff @(posedge clk) begin
    f_past_valid  <= 1'b1;
    f_after_check <= (state == S_CHECK);
  end

  always_comb begin
    if (!f_past_valid) assume (reset);
  end

  always_comb begin
    if (f_past_valid && !reset && ((state == S_CHECK) || f_after_check))
      assert (!diverge_now);
  end
`endif
`endif

endmodule

// File: tb/tb_sodor_lockstep_lb_monitor.sv
// ---------------------------------------------------------------------------
// tb_sodor_lockstep_lb_monitor
// Two monitor instances share clock and reset:
//   A: defaults (2 copies, 1 entry, 1-cycle window 14)
//   B: 3 copies, 4 entries, 4-cycle window 14..17
// Expected outputs come from a timeline/arithmetic model of the harness and a
// reference comparison of the stored LB tables in each cycle.
// ---------------------------------------------------------------------------
module tb_sodor_lockstep_lb_monitor;

  localparam int RC = 2, WC = 6, CS = 14, AW = 32, DW = 32;
  localparam int A_NC = 2, A_NE = 1, A_CL = 1;
  localparam int B_NC = 3, B_NE = 4, B_CL = 4;
  localparam int NCYC = 22;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A signals
  logic [A_NC*A_NE-1:0]    a_valid;
  logic [A_NC*A_NE*AW-1:0] a_addr;
  logic [A_NC*A_NE*DW-1:0] a_data;
  logic a_core_reset, a_init, a_check_win, a_diverge_now, a_diverge_sticky;
  logic [7:0] a_first_cycle;
  logic [0:0] a_first_copy;
  logic [0:0] a_first_entry;
  logic a_done, a_pass;

  // DUT B signals
  logic [B_NC*B_NE-1:0]    b_valid;
  logic [B_NC*B_NE*AW-1:0] b_addr;
  logic [B_NC*B_NE*DW-1:0] b_data;
  logic b_core_reset, b_init, b_check_win, b_diverge_now, b_diverge_sticky;
  logic [7:0] b_first_cycle;
  logic [1:0] b_first_copy;
  logic [2:0] b_first_entry;
  logic b_done, b_pass;

  sodor_lockstep_lb_monitor u_dut_a (
    .clk(clk), .reset(reset),
    .lb_valid(a_valid), .lb_addr(a_addr), .lb_data(a_data),
    .core_reset(a_core_reset), .init(a_init), .check_win(a_check_win),
    .diverge_now(a_diverge_now), .diverge_sticky(a_diverge_sticky),
    .first_cycle(a_first_cycle), .first_copy(a_first_copy),
    .first_entry(a_first_entry), .done(a_done), .pass(a_pass)
  );

  sodor_lockstep_lb_monitor #(
    .NUM_COPIES(B_NC), .LB_ENTRIES(B_NE), .CHECK_LEN(B_CL)
  ) u_dut_b (
    .clk(clk), .reset(reset),
    .lb_valid(b_valid), .lb_addr(b_addr), .lb_data(b_data),
    .core_reset(b_core_reset), .init(b_init), .check_win(b_check_win),
    .diverge_now(b_diverge_now), .diverge_sticky(b_diverge_sticky),
    .first_cycle(b_first_cycle), .first_copy(b_first_copy),
    .first_entry(b_first_entry), .done(b_done), .pass(b_pass)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit        v;
    bit [31:0] a;
    bit [31:0] d;
  } ent_t;

  ent_t s [2][3][4];           // [dut][copy][entry] current-cycle LB tables
  int   nc [2] = '{A_NC, B_NC};
  int   ne [2] = '{A_NE, B_NE};
  int   cl [2] = '{A_CL, B_CL};
  bit   m_sticky [2];
  bit   m_now    [2];
  int   m_fc     [2];
  int   m_fcopy  [2];
  int   m_fent   [2];

  function automatic int win_start();
    return (CS > RC + WC) ? CS : RC + WC;
  endfunction

  function automatic bit in_win(int d, int c);
    return (c >= win_start()) && (c < win_start() + cl[d]);
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_sticky[d] = 1'b0; m_now[d] = 1'b0;
      m_fc[d] = 0; m_fcopy[d] = 0; m_fent[d] = 0;
    end
  endtask

  // Applies the comparison rule to the tables driven during cycle c.
  task automatic model_step(int d, int c);
    bit any;
    int fk, fe;
    any = 1'b0; fk = 0; fe = 0;
    if (in_win(d, c)) begin
      for (int k = 1; k < nc[d]; k++) begin
        for (int e = 0; e < ne[d]; e++) begin
          bit diff;
          diff = (s[d][k][e].v != s[d][0][e].v) ||
                 (s[d][k][e].v && s[d][0][e].v &&
                  ((s[d][k][e].a != s[d][0][e].a) || (s[d][k][e].d != s[d][0][e].d)));
          if (diff && !any) begin any = 1'b1; fk = k; fe = e; end
        end
      end
    end
    m_now[d] = any;
    if (any && !m_sticky[d]) begin
      m_sticky[d] = 1'b1; m_fc[d] = c; m_fcopy[d] = fk; m_fent[d] = fe;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(string p, int d, int c, logic cr, logic in_, logic cw,
                           logic dn, logic ds, logic [7:0] fc, logic [1:0] fcp,
                           logic [2:0] fe, logic dne, logic ps);
    bit exp_done;
    exp_done = (c >= win_start() + cl[d]);
    chk($sformatf("%s.core_reset@%0d", p, c), 32'(cr),  32'(c < RC));
    chk($sformatf("%s.init@%0d", p, c),       32'(in_), 32'(c < RC + WC));
    chk($sformatf("%s.check_win@%0d", p, c),  32'(cw),  32'(in_win(d, c)));
    chk($sformatf("%s.done@%0d", p, c),       32'(dne), 32'(exp_done));
    chk($sformatf("%s.pass@%0d", p, c),       32'(ps),  32'(exp_done && !m_sticky[d]));
    chk($sformatf("%s.diverge_now@%0d", p, c),    32'(dn), 32'(m_now[d]));
    chk($sformatf("%s.diverge_sticky@%0d", p, c), 32'(ds), 32'(m_sticky[d]));
    chk($sformatf("%s.first_cycle@%0d", p, c),    32'(fc),  32'(m_fc[d]));
    chk($sformatf("%s.first_copy@%0d", p, c),     32'(fcp), 32'(m_fcopy[d]));
    chk($sformatf("%s.first_entry@%0d", p, c),    32'(fe),  32'(m_fent[d]));
  endtask

  task automatic check_all(int c);
    check_dut("A", 0, c, a_core_reset, a_init, a_check_win, a_diverge_now,
              a_diverge_sticky, a_first_cycle, {1'b0, a_first_copy},
              {2'b00, a_first_entry}, a_done, a_pass);
    check_dut("B", 1, c, b_core_reset, b_init, b_check_win, b_diverge_now,
              b_diverge_sticky, b_first_cycle, b_first_copy, b_first_entry,
              b_done, b_pass);
  endtask

  // ---------------- stimulus ----------------
  // scen 0 equal, 1 A valid split at 14, 2 B multi-mismatch, 3 invalid with
  // differing addr, 4 mismatch at 10, 5 random perturbations.
  task automatic gen(int scen, int c);
    for (int d = 0; d < 2; d++) begin
      for (int e = 0; e < 4; e++) begin
        ent_t base;
        base.v = 1'($urandom_range(0, 1));
        base.a = $urandom;
        base.d = $urandom;
        for (int k = 0; k < 3; k++) s[d][k][e] = base;
      end
    end
    case (scen)
      1: if (c == 14) begin s[0][0][0].v = 1'b0; s[0][1][0].v = 1'b1; end
      2: begin
        if (c == 15) begin
          for (int k = 0; k < 3; k++) begin s[1][k][3].v = 1'b1; s[1][k][3].d = 32'h10; end
          s[1][2][3].d = 32'h11;
        end
        if (c == 16) s[1][1][0].v = ~s[1][0][0].v;
      end
      3: begin
        for (int d = 0; d < 2; d++)
          for (int k = 0; k < 3; k++)
            for (int e = 0; e < 4; e++) begin
              s[d][k][e].v = 1'b0;
              s[d][k][e].a = (k == 0) ? 32'h100 : 32'h200;
              s[d][k][e].d = $urandom;
            end
      end
      4: if (c == 10) begin s[0][1][0].v = ~s[0][1][0].v; s[1][2][1].v = ~s[1][2][1].v; end
      5: begin
        for (int d = 0; d < 2; d++) begin
          if ($urandom_range(0, 2) == 0) begin
            int k, e;
            k = $urandom_range(1, nc[d] - 1);
            e = $urandom_range(0, ne[d] - 1);
            case ($urandom_range(0, 2))
              0:       s[d][k][e].v = ~s[d][k][e].v;
              1:       s[d][k][e].a = s[d][k][e].a ^ (32'h1 << $urandom_range(0, 31));
              default: s[d][k][e].d = s[d][k][e].d ^ (32'h1 << $urandom_range(0, 31));
            endcase
          end
        end
      end
      default: ;
    endcase
    for (int k = 0; k < A_NC; k++) begin
      a_valid[k] = s[0][k][0].v;
      a_addr[k*AW +: AW] = s[0][k][0].a;
      a_data[k*DW +: DW] = s[0][k][0].d;
    end
    for (int k = 0; k < B_NC; k++)
      for (int e = 0; e < B_NE; e++) begin
        b_valid[k*B_NE+e] = s[1][k][e].v;
        b_addr[(k*B_NE+e)*AW +: AW] = s[1][k][e].a;
        b_data[(k*B_NE+e)*DW +: DW] = s[1][k][e].d;
      end
  endtask

  // Reset, then walk cycles 0..ncyc checking each; optionally pulse reset at
  // cycle reset_at and verify reset values.
  task automatic run(int scen, int ncyc, int reset_at);
    reset = 1'b1;
    @(negedge clk);
    model_clear();
    check_all(0);
    reset = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      check_all(c);
      if (c == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        model_clear();
        check_all(0);
        reset = 1'b0;
        return;
      end
      gen(scen, c);
      model_step(0, c);
      model_step(1, c);
      @(negedge clk);
    end
    check_all(ncyc);
  endtask

  initial begin
    a_valid = '0; a_addr = '0; a_data = '0;
    b_valid = '0; b_addr = '0; b_data = '0;

    run(0, NCYC, -1);
    chk("dir.eq.A.pass", 32'(a_pass), 32'd1);
    chk("dir.eq.B.pass", 32'(b_pass), 32'd1);

    run(1, NCYC, -1);
    chk("dir.split.A.first_cycle", 32'(a_first_cycle), 32'd14);
    chk("dir.split.A.first_copy",  32'(a_first_copy),  32'd1);
    chk("dir.split.A.sticky",      32'(a_diverge_sticky), 32'd1);
    chk("dir.split.A.pass",        32'(a_pass), 32'd0);

    run(2, NCYC, -1);
    chk("dir.multi.B.first_cycle", 32'(b_first_cycle), 32'd15);
    chk("dir.multi.B.first_copy",  32'(b_first_copy),  32'd2);
    chk("dir.multi.B.first_entry", 32'(b_first_entry), 32'd3);
    chk("dir.multi.B.pass",        32'(b_pass), 32'd0);

    run(3, NCYC, -1);
    chk("dir.invalid.A.pass", 32'(a_pass), 32'd1);
    chk("dir.invalid.B.pass", 32'(b_pass), 32'd1);

    run(4, NCYC, -1);
    chk("dir.outside.A.pass", 32'(a_pass), 32'd1);
    chk("dir.outside.B.pass", 32'(b_pass), 32'd1);

    run(1, NCYC, 15);
    chk("dir.midreset.A.sticky", 32'(a_diverge_sticky), 32'd0);
    run(0, NCYC, -1);
    chk("dir.rerun.A.pass", 32'(a_pass), 32'd1);

    for (int i = 0; i < 10; i++) run(5, NCYC, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
